fm_audio_decimator: RTL and testbench
=====================================

# fm_audio_decimator

Downstream neighbour of the FM phase-difference demodulator. It accepts the signed 16-bit discriminator stream, integrates-and-dumps blocks of 2^LOG2_DECIM samples into one averaged audio sample, and applies a single-pole de-emphasis low-pass filter. The result is an audio-rate AXI-Stream for the audio output path. Both the input and output AXI-Stream interfaces honour backpressure.

## Interface
- LOG2_DECIM, 4: decimation factor = 2^LOG2_DECIM; legal 1..8.
- DEEMPH_SHIFT, 3: de-emphasis coefficient alpha = 2^-DEEMPH_SHIFT; 0 = filter bypassed; legal 0..8.
- C_S00_AXIS_TDATA_WIDTH, 32: input tdata width; fixed at 32.
- C_M00_AXIS_TDATA_WIDTH, 32: output tdata width; fixed at 32.
- s00_axis_aclk  in  1  single clock; all logic on the rising edge.
- s00_axis_areset  in  1  reset; synchronous, active-high.
- s00_axis_tvalid  in  1  input sample valid.
- s00_axis_tready  out  1  input ready.
- s00_axis_tdata  in  32  [15:0] signed discriminator sample; [31:16] ignored.
- s00_axis_tlast  in  1  end-of-packet marker.
- s00_axis_tstrb  in  4  ignored.
- m00_axis_tvalid  out  1  audio sample valid.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tdata  out  32  [15:0] signed audio sample; [31:16] = 0.
- m00_axis_tlast  out  1  set if any sample in the dumped block carried tlast.
- m00_axis_tstrb  out  4  4'hF whenever tvalid = 1; otherwise 0.

## Operation
- State registers:
  - cnt: block position, 0..2^LOG2_DECIM-1.
  - acc: signed, 16+LOG2_DECIM bits.
  - last_sticky.
  - y: signed 16-bit filter state.
  - Output register.
- Accept: s00_axis_tready = (cnt != 2^LOG2_DECIM-1) || !m00_axis_tvalid || m00_axis_tready.
  - The block never drops a sample and never overwrites an unconsumed output.
- On each input transfer with cnt < max:
  - acc += sign-extended sample.
  - cnt++.
  - last_sticky |= tlast.
- On the transfer with cnt = max (dump):
  - sum = acc + sample.
  - avg = sum >>> LOG2_DECIM. This is an arithmetic shift and floors toward -inf.
  - DEEMPH_SHIFT = 0: y_new = avg.
  - DEEMPH_SHIFT > 0: y_new = y + ((avg - y) >>> DEEMPH_SHIFT). The difference is computed in 17 bits and y_new stays within the int16 range, so no saturation logic is required.
  - y <= y_new.
  - m00_axis_tdata <= {16'b0, y_new}.
  - m00_axis_tlast <= last_sticky | tlast.
  - m00_axis_tvalid <= 1.
  - acc, cnt and last_sticky clear to 0.
- Output transfer without a simultaneous dump: m00_axis_tvalid <= 0.
- Output transfer with a simultaneous dump: the new sample is loaded and tvalid stays 1, giving zero bubbles.
- tlast does not force an early dump. Blocks stay aligned to the sample count.

## Timing
- Reset clears every register to 0: cnt, acc, last_sticky, y, m00_axis_tvalid/tdata/tlast/tstrb.
  - s00_axis_tready reads 1 during and after reset; it is combinational from the cleared state.
  - Reset mid-block discards the partial accumulation and the filter history.
- Latency: m00_axis_tvalid rises on the clock edge that accepts the final sample of a block.
- Throughput: one input per cycle sustained. Stalls occur only when a dump is due while the output is held.
- m00_axis_tdata/tlast are stable while tvalid = 1 and tready = 0.
- No combinational path from s00_axis_tvalid to any output. s00_axis_tready depends on m00_axis_tready combinationally; this is permitted.

## Structure
- Shared package fm_pkg holds:
  - typedef sample_t (logic signed [15:0]).
  - Localparam AUDIO_W = 16.
  - The derived function decim_len(LOG2_DECIM).
- One natural sub-module, deemph_iir: the combinational y_new computation, parameterised by DEEMPH_SHIFT. Its state register y stays in the top level.
- Everything else (counter, accumulator, output register) lives in fm_audio_decimator.

## Test plan
- Basic average (LOG2_DECIM=2, DEEMPH_SHIFT=0, tready always 1):
  - Inputs 4, 8, 12, 16 -> one output, tdata = 0x0000000A, tstrb = 0xF.
  - m00_axis_tvalid high exactly 1 cycle.
- Floor rounding and extremes (LOG2_DECIM=2, DEEMPH_SHIFT=0):
  - Inputs -1, -2, -2, -2 -> 0x0000FFFE (-2).
  - Four 32767 -> 0x00007FFF.
  - Four -32768 -> 0x00008000.
- De-emphasis (LOG2_DECIM=2, DEEMPH_SHIFT=2):
  - Two blocks of four 1000 -> outputs 250 then 437.
  - Third block of four 0 -> 437 + (-437 >>> 2) = 437 - 110 = 327.
- Backpressure (LOG2_DECIM=2):
  - Hold m00_axis_tready = 0 after the first output while driving continuous valid inputs.
  - Required: s00_axis_tready drops only when cnt = 3; the first output holds unchanged.
  - After tready is released: the second output is 4 samples later, with no loss and no duplication.
- Back-to-back full rate (m00_axis_tready = 1): 64 inputs -> 16 outputs, with s00_axis_tready constantly 1.
- tlast and reset:
  - tlast on the 2nd sample of a block -> that block's output has tlast = 1; the next block has tlast = 0.
  - Reset after 2 samples, then four 100 (DEEMPH_SHIFT=0) -> output 100.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared types and helpers for the FM audio back end.
`timescale 1ns/1ps
package fm_pkg;

    localparam int AUDIO_W = 16;

    typedef logic signed [AUDIO_W-1:0] sample_t;

    function automatic int decim_len(input int log2_decim);
        return 1 << log2_decim;
    endfunction

endpackage

// File: rtl/fm_audio_decimator_deemph_iir.sv
// Single-pole de-emphasis step: y_new = y + ((avg - y) >>> DEEMPH_SHIFT), or avg when bypassed.
`timescale 1ns/1ps
module deemph_iir
    import fm_pkg::*;
#(
    parameter int DEEMPH_SHIFT = 3
) (
    input  sample_t y,
    input  sample_t avg,
    output sample_t y_new
);

    localparam int DIFF_W = AUDIO_W + 1;

    function automatic logic signed [DIFF_W-1:0] shr_floor(input logic signed [DIFF_W-1:0] v);
        return v >>> DEEMPH_SHIFT;
    endfunction

    generate
        if (DEEMPH_SHIFT == 0) begin : g_bypass
            sample_t unused_y;
            assign unused_y = y;
            assign y_new    = avg;
        end else begin : g_iir
            logic signed [DIFF_W-1:0] diff;
            logic signed [DIFF_W-1:0] step;
            logic signed [DIFF_W-1:0] total;
            logic                     unused_msb;

            // The step never overshoots avg, so the sum always fits back into 16 bits.
            assign diff       = $signed({avg[AUDIO_W-1], avg}) - $signed({y[AUDIO_W-1], y});
            assign step       = shr_floor(diff);
            assign total      = $signed({y[AUDIO_W-1], y}) + step;
            assign y_new      = total[AUDIO_W-1:0];
            assign unused_msb = total[DIFF_W-1];
        end
    endgenerate

endmodule

// File: rtl/fm_audio_decimator.sv
// Integrate-and-dump decimator with de-emphasis, turning the discriminator stream into audio-rate AXI-Stream.
`timescale 1ns/1ps
module fm_audio_decimator
    import fm_pkg::*;
#(
    parameter int LOG2_DECIM             = 4,
    parameter int DEEMPH_SHIFT           = 3,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_areset,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                              s00_axis_tlast,
    input  logic [3:0]                        s00_axis_tstrb,
    output logic                              m00_axis_tvalid,
    input  logic                              m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                              m00_axis_tlast,
    output logic [3:0]                        m00_axis_tstrb
);

    localparam int DLEN  = decim_len(LOG2_DECIM);
    localparam int ACC_W = AUDIO_W + LOG2_DECIM;

    generate
        if (LOG2_DECIM < 1 || LOG2_DECIM > 8 || DEEMPH_SHIFT < 0 || DEEMPH_SHIFT > 8 ||
            C_S00_AXIS_TDATA_WIDTH != 32 || C_M00_AXIS_TDATA_WIDTH != 32 || DLEN < 2) begin : g_bad_param
            $error("fm_audio_decimator: unsupported parameter set");
        end
    endgenerate

    // Floor average: dropping the low LOG2_DECIM bits of a two's-complement sum rounds toward -inf.
    function automatic sample_t floor_avg(input logic signed [ACC_W-1:0] v);
        return sample_t'(v[ACC_W-1:LOG2_DECIM]);
    endfunction

    logic [LOG2_DECIM-1:0]   cnt;
    logic signed [ACC_W-1:0] acc;
    logic                    last_sticky;
    sample_t                 y;
    sample_t                 out_audio;
    logic                    out_vld;
    logic                    out_last;

    sample_t                 sample;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] sum;
    sample_t                 avg;
    sample_t                 y_new;
    logic                    cnt_max;
    logic                    in_xfer;
    logic                    out_xfer;
    logic                    dump;
    logic                    unused_bits;

    assign sample      = s00_axis_tdata[AUDIO_W-1:0];
    assign sample_ext  = {{LOG2_DECIM{sample[AUDIO_W-1]}}, sample};
    assign sum         = acc + sample_ext;
    assign avg         = floor_avg(sum);
    assign unused_bits = ^{s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:AUDIO_W], s00_axis_tstrb};

    assign cnt_max  = &cnt;
    assign out_xfer = out_vld & m00_axis_tready;
    assign in_xfer  = s00_axis_tvalid & s00_axis_tready;
    assign dump     = in_xfer & cnt_max;

    // Stall only the dumping sample, and only while the previous result is still unconsumed.
    assign s00_axis_tready = !cnt_max || !out_vld || m00_axis_tready;

    deemph_iir #(
        .DEEMPH_SHIFT(DEEMPH_SHIFT)
    ) u_deemph (
        .y    (y),
        .avg  (avg),
        .y_new(y_new)
    );

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            cnt         <= '0;
            acc         <= '0;
            last_sticky <= 1'b0;
            y           <= '0;
            out_audio   <= '0;
            out_vld     <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            if (in_xfer) begin
                if (cnt_max) begin
                    cnt         <= '0;
                    acc         <= '0;
                    last_sticky <= 1'b0;
                    y           <= y_new;
                    out_audio   <= y_new;
                    out_last    <= last_sticky | s00_axis_tlast;
                    out_vld     <= 1'b1;
                end else begin
                    cnt         <= cnt + 1'b1;
                    acc         <= sum;
                    last_sticky <= last_sticky | s00_axis_tlast;
                end
            end
            // A dump in the same cycle reloads the register, so tvalid stays up without a bubble.
            if (out_xfer && !dump) begin
                out_vld <= 1'b0;
            end
        end
    end

    assign m00_axis_tvalid = out_vld;
    assign m00_axis_tdata  = {{(C_M00_AXIS_TDATA_WIDTH-AUDIO_W){1'b0}}, out_audio};
    assign m00_axis_tlast  = out_last;
    assign m00_axis_tstrb  = {4{out_vld}};

endmodule

// File: tb/tb_fm_audio_decimator.sv
// Directed bench: one instance with de-emphasis bypassed and one with DEEMPH_SHIFT=2, both LOG2_DECIM=2.
`timescale 1ns/1ps
module tb_fm_audio_decimator;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_tvalid;
    logic        s_tlast;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;
    logic        m_tready;

    logic        a_s_tready, a_m_tvalid, a_m_tlast;
    logic [31:0] a_m_tdata;
    logic [3:0]  a_m_tstrb;
    logic        b_s_tready, b_m_tvalid, b_m_tlast;
    logic [31:0] b_m_tdata;
    logic [3:0]  b_m_tstrb;

    always #5 clk = ~clk;

    fm_audio_decimator #(
        .LOG2_DECIM(2), .DEEMPH_SHIFT(0),
        .C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(32)
    ) dut_a (
        .s00_axis_aclk(clk), .s00_axis_areset(rst),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tready(a_s_tready),
        .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast), .s00_axis_tstrb(s_tstrb),
        .m00_axis_tvalid(a_m_tvalid), .m00_axis_tready(m_tready),
        .m00_axis_tdata(a_m_tdata), .m00_axis_tlast(a_m_tlast), .m00_axis_tstrb(a_m_tstrb)
    );

    fm_audio_decimator #(
        .LOG2_DECIM(2), .DEEMPH_SHIFT(2),
        .C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(32)
    ) dut_b (
        .s00_axis_aclk(clk), .s00_axis_areset(rst),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tready(b_s_tready),
        .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast), .s00_axis_tstrb(s_tstrb),
        .m00_axis_tvalid(b_m_tvalid), .m00_axis_tready(m_tready),
        .m00_axis_tdata(b_m_tdata), .m00_axis_tlast(b_m_tlast), .m00_axis_tstrb(b_m_tstrb)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [3:0]  strb;
    } out_t;

    typedef struct {
        logic [3:0][15:0] s;
        int               last_pos;
        logic [15:0]      exp_a;
        logic             exp_last;
        logic [15:0]      exp_b;
    } vec_t;

    out_t qa[$];
    out_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   ready_drops = 0;
    int   ready_diff = 0;
    logic watch_ready = 1'b0;
    vec_t vecs[6];

    // Monitor: observes each cycle 2 ns after the falling edge; a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        #2;
        if (a_m_tvalid && m_tready) qa.push_back('{a_m_tdata, a_m_tlast, a_m_tstrb});
        if (b_m_tvalid && m_tready) qb.push_back('{b_m_tdata, b_m_tlast, b_m_tstrb});
        if (a_s_tready !== b_s_tready) ready_diff++;
        if (watch_ready && s_tvalid && !a_s_tready) ready_drops++;
    end

    function automatic vec_t mk(input int s0, input int s1, input int s2, input int s3,
                                input int lp, input int ea, input logic el, input int eb);
        vec_t v;
        v.s[0]     = 16'(s0);
        v.s[1]     = 16'(s1);
        v.s[2]     = 16'(s2);
        v.s[3]     = 16'(s3);
        v.last_pos = lp;
        v.exp_a    = 16'(ea);
        v.exp_last = el;
        v.exp_b    = 16'(eb);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_out(input bit from_b, input string name, input logic [15:0] d, input logic l);
        out_t o;
        if ((from_b ? qb.size() : qa.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no output, expected data 0x%04h", name, d);
        end else begin
            o = from_b ? qb.pop_front() : qa.pop_front();
            chk({name, "_data"}, o.data, {16'h0, d});
            chk({name, "_last"}, 32'(o.last), 32'(l));
            chk({name, "_strb"}, 32'(o.strb), 32'hF);
        end
    endtask

    task automatic send(input logic [15:0] v, input logic l);
        int guard;
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = {16'hABCD, v};
        s_tlast  = l;
        #2;
        guard = 0;
        while (!a_s_tready && guard < 50) begin
            @(negedge clk);
            #2;
            guard++;
        end
        if (!a_s_tready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tready still 0, required 1 within 50 cycles");
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        #2;
        chk({name, "_tready_in_reset"}, 32'(a_s_tready), 32'd1);
        @(negedge clk);
        #2;
        chk({name, "_tvalid"}, 32'(a_m_tvalid), 32'd0);
        chk({name, "_tdata"}, a_m_tdata | b_m_tdata, 32'd0);
        chk({name, "_tstrb_tlast"}, {27'd0, a_m_tstrb, a_m_tlast}, 32'd0);
        chk({name, "_tready"}, 32'(a_s_tready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    initial begin
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        s_tstrb  = 4'h0;
        m_tready = 1'b1;

        // Expected values: A = floor(sum/4); B = y + floor((A - y)/4) carried across blocks.
        vecs[0] = mk(4, 8, 12, 16, -1, 10, 1'b0, 2);
        vecs[1] = mk(-1, -2, -2, -2, -1, -2, 1'b0, 1);
        vecs[2] = mk(32767, 32767, 32767, 32767, -1, 32767, 1'b0, 8192);
        vecs[3] = mk(-32768, -32768, -32768, -32768, -1, -32768, 1'b0, -2048);
        vecs[4] = mk(5, 5, 5, 5, 1, 5, 1'b1, -1535);
        vecs[5] = mk(0, 0, 0, 0, -1, 0, 1'b0, -1152);

        do_reset("rst0");

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 4; k++) send(vecs[i].s[k], k == vecs[i].last_pos);
        end
        idle(3);
        chk("table_count_a", 32'(qa.size()), 32'd6);
        chk("table_count_b", 32'(qb.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            expect_out(1'b0, $sformatf("tbl%0d_a", i), vecs[i].exp_a, vecs[i].exp_last);
            expect_out(1'b1, $sformatf("tbl%0d_b", i), vecs[i].exp_b, vecs[i].exp_last);
        end

        // De-emphasis step response and decay from a fresh filter state.
        do_reset("rst1");
        for (int k = 0; k < 8; k++) send(16'd1000, 1'b0);
        for (int k = 0; k < 4; k++) send(16'd0, 1'b0);
        idle(3);
        expect_out(1'b1, "deemph0", 16'd250, 1'b0);
        expect_out(1'b1, "deemph1", 16'd437, 1'b0);
        expect_out(1'b1, "deemph2", 16'd327, 1'b0);
        expect_out(1'b0, "deemph_bypass0", 16'd1000, 1'b0);
        expect_out(1'b0, "deemph_bypass1", 16'd1000, 1'b0);
        expect_out(1'b0, "deemph_bypass2", 16'd0, 1'b0);

        // Reset mid-block must drop the partial sum and the filter history.
        send(16'd7, 1'b0);
        send(16'd9, 1'b1);
        do_reset("rst_mid");
        for (int k = 0; k < 4; k++) send(16'd100, 1'b0);
        idle(3);
        expect_out(1'b0, "after_rst_a", 16'd100, 1'b0);
        expect_out(1'b1, "after_rst_b", 16'd25, 1'b0);
        chk("after_rst_extra", 32'(qa.size()), 32'd0);

        // Sustained full rate: block k holds 4k..4k+3, average 4k+1.
        do_reset("rst2");
        watch_ready = 1'b1;
        for (int i = 0; i < 64; i++) send(16'(i), 1'b0);
        idle(3);
        watch_ready = 1'b0;
        chk("fullrate_ready_drops", 32'(ready_drops), 32'd0);
        chk("fullrate_count", 32'(qa.size()), 32'd16);
        for (int k = 0; k < 16; k++) expect_out(1'b0, $sformatf("fullrate%0d", k), 16'(4 * k + 1), 1'b0);
        qb.delete();

        // Backpressure: first result held while the next block fills up to its last sample.
        do_reset("rst3");
        @(negedge clk);
        m_tready = 1'b0;
        for (int k = 0; k < 4; k++) send(16'd20, 1'b0);
        for (int k = 0; k < 3; k++) send(16'd30, 1'b0);
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = 32'd30;
        s_tlast  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("bp_stall_tready%0d", i), 32'(a_s_tready), 32'd0);
            chk($sformatf("bp_hold%0d", i), {a_m_tvalid, a_m_tdata[30:0]}, {1'b1, 31'd20});
            @(negedge clk);
        end
        m_tready = 1'b1;
        #2;
        chk("bp_release_tready", 32'(a_s_tready), 32'd1);
        @(posedge clk);
        for (int k = 0; k < 4; k++) send(16'd40, 1'b0);
        idle(3);
        chk("bp_count", 32'(qa.size()), 32'd3);
        expect_out(1'b0, "bp_out0", 16'd20, 1'b0);
        expect_out(1'b0, "bp_out1", 16'd30, 1'b0);
        expect_out(1'b0, "bp_out2", 16'd40, 1'b0);

        chk("tready_agree", 32'(ready_diff), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
